dino_jump_ctrl: RTL

//  Player-motion stage between the raw up/down buttons and the sprite renderer feeding VGA.

---
 rtl/dino_pkg.sv | 25 ++
 rtl/dino_jump_ctrl_btn_sampler.sv | 35 +++
 rtl/dino_jump_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared constants for the dino player-motion stage: FSM state codes,
// default physics parameters and the sampled-button bundle.
package dino_pkg;

    localparam logic [2:0] RUN  = 3'd0;
    localparam logic [2:0] DUCK = 3'd1;
    localparam logic [2:0] RISE = 3'd2;
    localparam logic [2:0] FALL = 3'd3;
    localparam logic [2:0] HALT = 3'd4;

    localparam int DEF_Y_W     = 8;
    localparam int DEF_V_W     = 5;
    localparam int DEF_JUMP_V  = 14;
    localparam int DEF_GRAVITY = 1;
    localparam int DEF_FAST_G  = 3;
    localparam int DEF_Y_MAX   = 120;
    localparam int DEF_V_MAX   = 15;

    // lvl: this frame's synced button level; rise: pressed this frame, not last frame
    typedef struct packed {
        logic lvl;
        logic rise;
    } btn_smp_t;

endpackage

// File: rtl/dino_jump_ctrl_btn_sampler.sv
// Button front end: 2-FF synchroniser, per-frame sample history and
// frame-to-frame rising-edge detect.
module btn_sampler
    import dino_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick_i,
    input  logic     btn_i,
    output btn_smp_t smp_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (tick_i) begin
                prev_q <= sync_q[1];
            end
        end
    end

    // The frame sample is the synced level at the tick itself, so a raw edge
    // landing on the tick cycle is only seen by the following frame.
    always_comb begin
        smp_o.lvl  = sync_q[1];
        smp_o.rise = sync_q[1] & ~prev_q;
    end

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino player-motion stage: frame-rate run/duck/rise/fall/halt FSM with
// integer gravity, publishing height above ground and pose flags.
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int Y_W     = DEF_Y_W,
    parameter int V_W     = DEF_V_W,
    parameter int JUMP_V  = DEF_JUMP_V,
    parameter int GRAVITY = DEF_GRAVITY,
    parameter int FAST_G  = DEF_FAST_G,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int V_MAX   = DEF_V_MAX
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           up,
    input  logic           down,
    input  logic           game_over,
    output logic [Y_W-1:0] dino_y,
    output logic           duck,
    output logic           airborne,
    output logic           landed
);

    localparam logic [Y_W:0]   Y_MAX_X = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W-1:0] Y_MAX_N = Y_W'(Y_MAX);
    localparam logic [V_W:0]   V_MAX_X = (V_W+1)'(V_MAX);
    localparam logic [V_W-1:0] V_MAX_N = V_W'(V_MAX);
    localparam logic [V_W-1:0] JUMP_N  = V_W'(JUMP_V);
    localparam logic [V_W-1:0] G_SLOW  = V_W'(GRAVITY);
    localparam logic [V_W-1:0] G_FAST  = V_W'(FAST_G);

    btn_smp_t up_smp, dn_smp;
    logic     dn_rise_unused;

    btn_sampler u_up_smp (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (frame_tick),
        .btn_i  (up),
        .smp_o  (up_smp)
    );

    btn_sampler u_dn_smp (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (frame_tick),
        .btn_i  (down),
        .smp_o  (dn_smp)
    );

    assign dn_rise_unused = dn_smp.rise;

    logic [2:0]     state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [V_W-1:0] vel_q, vel_d;
    logic [V_W-1:0] fv_q, fv_d;
    logic           landed_q, landed_d;

    logic [V_W-1:0] g_eff;
    logic [Y_W:0]   y_sum;
    logic [Y_W:0]   fv_ext;
    logic [V_W:0]   fv_sum;

    // Sums carry one guard bit so saturation is decided before any wrap.
    always_comb begin
        g_eff  = dn_smp.lvl ? G_FAST : G_SLOW;
        y_sum  = {1'b0, y_q} + (Y_W+1)'(vel_q);
        fv_ext = (Y_W+1)'(fv_q);
        fv_sum = {1'b0, fv_q} + {1'b0, g_eff};
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        fv_d     = fv_q;
        landed_d = 1'b0;
        if (frame_tick) begin
            case (state_q)
                RUN, DUCK: begin
                    if (game_over) begin
                        state_d = HALT;
                    end else if (up_smp.rise) begin
                        state_d = RISE;
                        vel_d   = JUMP_N;
                    end else if (dn_smp.lvl) begin
                        state_d = DUCK;
                    end else begin
                        state_d = RUN;
                    end
                end
                RISE: begin
                    if (game_over) begin
                        state_d = HALT;
                    end else begin
                        y_d = (y_sum > Y_MAX_X) ? Y_MAX_N : y_sum[Y_W-1:0];
                        if (vel_q <= g_eff) begin
                            state_d = FALL;
                            fv_d    = '0;
                        end else begin
                            vel_d = vel_q - g_eff;
                        end
                    end
                end
                FALL: begin
                    if (game_over) begin
                        state_d = HALT;
                    end else if ({1'b0, y_q} <= fv_ext) begin
                        y_d      = '0;
                        landed_d = 1'b1;
                        state_d  = dn_smp.lvl ? DUCK : RUN;
                    end else begin
                        y_d  = y_q - fv_ext[Y_W-1:0];
                        fv_d = (fv_sum > V_MAX_X) ? V_MAX_N : fv_sum[V_W-1:0];
                    end
                end
                HALT: begin
                    if (!game_over) begin
                        state_d = RUN;
                        y_d     = '0;
                        vel_d   = '0;
                        fv_d    = '0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            y_q      <= '0;
            vel_q    <= '0;
            fv_q     <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            fv_q     <= fv_d;
            landed_q <= landed_d;
        end
    end

    assign dino_y   = y_q;
    assign duck     = (state_q == DUCK);
    assign airborne = (state_q == RISE) || (state_q == FALL);
    assign landed   = landed_q;

endmodule
